zeroheti_obi_apb_bridge: RTL and testbench

ZEROHETI_OBI_APB_BRIDGE -- requirements
Module: zeroheti_obi_apb_bridge

---
 rtl/zeroheti_pkg.sv | 18 +
 rtl/zeroheti_apb_decoder.sv | 26 ++
 rtl/zeroheti_obi_apb_bridge.sv | 137 +++++++++++++
 tb/tb_zeroheti_obi_apb_bridge.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_pkg.sv
// Shared types and constants for the OBI-to-APB bridge.
package zeroheti_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

  localparam int unsigned DefaultTimeoutCycles = 256;

  // Completer index width; a single completer still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zeroheti_apb_decoder.sv
// Maps an OBI address onto one of NumSlv equally sized, contiguous APB windows.
module zeroheti_apb_decoder
  import zeroheti_pkg::*;
#(
  parameter int unsigned NumSlv      = 4,
  parameter logic [31:0] BaseAddr    = 32'h0003_0000,
  parameter int unsigned SlvAddrBits = 12,
  parameter int unsigned IdxW        = idx_width(NumSlv)
) (
  input  logic [31:0]     addr,
  output logic            hit,
  output logic [IdxW-1:0] idx
);

  logic [31:0] offset;
  logic [31:0] slot;

  // Addresses below the base wrap to huge offsets, so the explicit lower bound is needed.
  always_comb begin
    offset = addr - BaseAddr;
    slot   = offset >> SlvAddrBits;
    hit    = (addr >= BaseAddr) && (slot < 32'(NumSlv));
    idx    = slot[IdxW-1:0];
  end

endmodule

// File: rtl/zeroheti_obi_apb_bridge.sv
// Single-outstanding OBI to APB4 bridge: IDLE -> SETUP -> ACCESS -> RESP, with decode-miss and timeout errors.
module zeroheti_obi_apb_bridge
  import zeroheti_pkg::*;
#(
  parameter int unsigned NumSlv        = 4,
  parameter logic [31:0] BaseAddr      = 32'h0003_0000,
  parameter int unsigned SlvAddrBits   = 12,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // OBI request: obi_gnt_o = obi_req_i in IDLE/RESP; a transfer is accepted when req && gnt.
  input  logic                     obi_req_i,
  output logic                     obi_gnt_o,
  input  logic [31:0]              obi_addr_i,
  input  logic                     obi_we_i,
  input  logic [3:0]               obi_be_i,
  input  logic [31:0]              obi_wdata_i,
  // OBI response: obi_rvalid_o pulses for one cycle per accepted transfer, no backpressure.
  output logic                     obi_rvalid_o,
  output logic [31:0]              obi_rdata_o,
  output logic                     obi_err_o,
  output logic [31:0]              paddr_o,
  output logic                     pwrite_o,
  output logic [31:0]              pwdata_o,
  output logic [3:0]               pstrb_o,
  output logic [2:0]               pprot_o,
  output logic                     penable_o,
  output logic [NumSlv-1:0]        psel_o,
  input  logic [NumSlv-1:0][31:0]  prdata_i,
  input  logic [NumSlv-1:0]        pready_i,
  input  logic [NumSlv-1:0]        pslverr_i,
  output bridge_state_e            state_o
);

  localparam int unsigned IdxW = idx_width(NumSlv);
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  bridge_state_e   state;
  logic [IdxW-1:0] idx;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_next;
  logic            dec_hit;
  logic [IdxW-1:0] dec_idx;
  logic            sel_ready;
  logic            sel_err;

  zeroheti_apb_decoder #(
    .NumSlv      (NumSlv),
    .BaseAddr    (BaseAddr),
    .SlvAddrBits (SlvAddrBits),
    .IdxW        (IdxW)
  ) u_decoder (
    .addr (obi_addr_i),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Only the addressed completer's response is looked at.
  always_comb begin
    obi_gnt_o = obi_req_i && ((state == ST_IDLE) || (state == ST_RESP));
    cnt_next  = cnt + CntW'(1);
    sel_ready = pready_i[idx];
    sel_err   = pslverr_i[idx];
  end

  assign pprot_o = 3'b000;
  assign state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      idx          <= '0;
      cnt          <= '0;
      obi_rvalid_o <= 1'b0;
      obi_rdata_o  <= '0;
      obi_err_o    <= 1'b0;
      paddr_o      <= '0;
      pwrite_o     <= 1'b0;
      pwdata_o     <= '0;
      pstrb_o      <= '0;
      penable_o    <= 1'b0;
      psel_o       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          obi_rvalid_o <= 1'b0;
          obi_err_o    <= 1'b0;
          obi_rdata_o  <= '0;
          state        <= ST_IDLE;
          if (obi_req_i) begin
            if (dec_hit) begin
              idx       <= dec_idx;
              cnt       <= '0;
              paddr_o   <= obi_addr_i;
              pwrite_o  <= obi_we_i;
              pwdata_o  <= obi_wdata_i;
              pstrb_o   <= obi_we_i ? obi_be_i : 4'b0000;
              psel_o    <= NumSlv'(1) << dec_idx;
              penable_o <= 1'b0;
              state     <= ST_SETUP;
            end else begin
              // Decode miss: answer immediately, never touch the APB side.
              obi_rvalid_o <= 1'b1;
              obi_err_o    <= 1'b1;
              state        <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          penable_o <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            psel_o       <= '0;
            penable_o    <= 1'b0;
            obi_rvalid_o <= 1'b1;
            obi_err_o    <= sel_err;
            obi_rdata_o  <= (!pwrite_o && !sel_err) ? prdata_i[idx] : '0;
            state        <= ST_RESP;
          end else if (cnt_next == CntW'(TimeoutCycles)) begin
            psel_o       <= '0;
            penable_o    <= 1'b0;
            obi_rvalid_o <= 1'b1;
            obi_err_o    <= 1'b1;
            state        <= ST_RESP;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zeroheti_obi_apb_bridge.sv
// Directed bench for the OBI-to-APB bridge with behavioural APB completers and a response scoreboard.
module tb_zeroheti_obi_apb_bridge;
  import zeroheti_pkg::*;

  localparam int NumSlv = 4;

  logic                    clk;
  logic                    rst;
  logic                    obi_req;
  logic                    obi_gnt;
  logic [31:0]             obi_addr;
  logic                    obi_we;
  logic [3:0]              obi_be;
  logic [31:0]             obi_wdata;
  logic                    obi_rvalid;
  logic [31:0]             obi_rdata;
  logic                    obi_err;
  logic [31:0]             paddr;
  logic                    pwrite;
  logic [31:0]             pwdata;
  logic [3:0]              pstrb;
  logic [2:0]              pprot;
  logic                    penable;
  logic [NumSlv-1:0]       psel;
  logic [NumSlv-1:0][31:0] prdata;
  logic [NumSlv-1:0]       pready;
  logic [NumSlv-1:0]       pslverr;
  bridge_state_e           state;

  zeroheti_obi_apb_bridge #(
    .NumSlv        (NumSlv),
    .BaseAddr      (32'h0003_0000),
    .SlvAddrBits   (12),
    .TimeoutCycles (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .obi_req_i    (obi_req),
    .obi_gnt_o    (obi_gnt),
    .obi_addr_i   (obi_addr),
    .obi_we_i     (obi_we),
    .obi_be_i     (obi_be),
    .obi_wdata_i  (obi_wdata),
    .obi_rvalid_o (obi_rvalid),
    .obi_rdata_o  (obi_rdata),
    .obi_err_o    (obi_err),
    .paddr_o      (paddr),
    .pwrite_o     (pwrite),
    .pwdata_o     (pwdata),
    .pstrb_o      (pstrb),
    .pprot_o      (pprot),
    .penable_o    (penable),
    .psel_o       (psel),
    .prdata_i     (prdata),
    .pready_i     (pready),
    .pslverr_i    (pslverr),
    .state_o      (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural completers ----------------
  int          wait_cfg  [NumSlv];
  bit          never_rdy [NumSlv];
  bit          err_cfg   [NumSlv];
  logic [31:0] rdata_cfg [NumSlv];
  int          acc_cnt   [NumSlv];

  // Unselected completers shout ready+error so any leak into the bridge is visible.
  always_comb begin
    for (int k = 0; k < NumSlv; k++) begin
      prdata[k] = rdata_cfg[k];
      if (psel[k]) begin
        pready[k]  = penable && !never_rdy[k] && (acc_cnt[k] >= wait_cfg[k]);
        pslverr[k] = err_cfg[k];
      end else begin
        pready[k]  = 1'b1;
        pslverr[k] = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NumSlv; k++) begin
      if (psel[k] && penable && !pready[k]) acc_cnt[k] <= acc_cnt[k] + 1;
      else if (!psel[k]) acc_cnt[k] <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int passed = 0;
  int total  = 0;
  int rv_count = 0;
  int psel_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (psel != '0) psel_cycles++;
    if (obi_rvalid === 1'b1) begin
      logic [32:0] e;
      rv_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", 32'(obi_err), 32'(e[32]));
        check("rsp_rdata", obi_rdata, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic grant_one(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input bit push, input logic [32:0] exp,
                           output int g);
    @(posedge clk); #1;
    obi_req = 1'b1; obi_addr = a; obi_we = we; obi_be = be; obi_wdata = wd;
    @(negedge clk);
    check("gnt_idle", 32'(obi_gnt), 32'd1);
    g = cyc;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    obi_req = 1'b0;
  endtask

  task automatic wait_rvalid(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (obi_rvalid === 1'b1) begin
        c = cyc;
        return;
      end
    end
    check("rvalid_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int g, c, rv_before;
  int gcyc[3];
  logic [31:0] b2b_addr[3];
  logic        b2b_we[3];
  logic [32:0] b2b_exp[3];

  initial begin
    rst = 1'b1; obi_req = 1'b0; obi_addr = '0; obi_we = 1'b0; obi_be = '0; obi_wdata = '0;
    for (int k = 0; k < NumSlv; k++) begin
      wait_cfg[k] = 0; never_rdy[k] = 1'b0; err_cfg[k] = 1'b0;
      rdata_cfg[k] = 32'hD00D_0000 + 32'(k);
    end
    rdata_cfg[1] = 32'hCAFE_0001;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_rvalid", 32'(obi_rvalid), 32'd0);
    check("rst_gnt", 32'(obi_gnt), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    rst = 1'b0;

    // Zero-wait read from completer 1
    grant_one(32'h0003_1004, 1'b0, 4'hF, 32'h0, 1'b1, {1'b0, 32'hCAFE_0001}, g);
    @(negedge clk);
    check("rd_setup_psel", 32'(psel), 32'b0010);
    check("rd_setup_penable", 32'(penable), 32'd0);
    check("rd_setup_paddr", paddr, 32'h0003_1004);
    check("rd_setup_pstrb", 32'(pstrb), 32'd0);
    check("rd_setup_pwrite", 32'(pwrite), 32'd0);
    check("rd_setup_gnt", 32'(obi_gnt), 32'd0);
    check("rd_pprot", 32'(pprot), 32'd0);
    @(negedge clk);
    check("rd_access_psel", 32'(psel), 32'b0010);
    check("rd_access_penable", 32'(penable), 32'd1);
    wait_rvalid(c);
    check("rd_latency", 32'(c - g), 32'd3);
    check("rd_resp_psel", 32'(psel), 32'd0);

    // Write to completer 2 with three wait states
    wait_cfg[2] = 3;
    grant_one(32'h0003_2000, 1'b1, 4'b0011, 32'h1234_5678, 1'b1, {1'b0, 32'h0}, g);
    @(negedge clk);
    check("wr_setup_psel", 32'(psel), 32'b0100);
    check("wr_setup_penable", 32'(penable), 32'd0);
    check("wr_setup_pwrite", 32'(pwrite), 32'd1);
    check("wr_setup_pstrb", 32'(pstrb), 32'b0011);
    check("wr_setup_pwdata", pwdata, 32'h1234_5678);
    repeat (4) begin
      @(negedge clk);
      check("wr_access_psel", 32'(psel), 32'b0100);
      check("wr_access_penable", 32'(penable), 32'd1);
      check("wr_stable_paddr", paddr, 32'h0003_2000);
      check("wr_stable_pstrb", 32'(pstrb), 32'b0011);
      check("wr_stable_pwdata", pwdata, 32'h1234_5678);
    end
    wait_rvalid(c);
    check("wr_latency", 32'(c - g), 32'd6);
    wait_cfg[2] = 0;

    // Decode miss
    #1 psel_cycles = 0;
    grant_one(32'h0004_0000, 1'b0, 4'hF, 32'h0, 1'b1, {1'b1, 32'h0}, g);
    wait_rvalid(c);
    check("miss_latency", 32'(c - g), 32'd1);
    #1 check("miss_no_psel", 32'(psel_cycles), 32'd0);

    // Completer error response on a read
    err_cfg[3] = 1'b1;
    grant_one(32'h0003_3008, 1'b0, 4'hF, 32'h0, 1'b1, {1'b1, 32'h0}, g);
    wait_rvalid(c);
    check("slverr_latency", 32'(c - g), 32'd3);
    err_cfg[3] = 1'b0;

    // Timeout on a never-ready completer 0
    never_rdy[0] = 1'b1;
    #1 psel_cycles = 0;
    grant_one(32'h0003_0010, 1'b0, 4'hF, 32'h0, 1'b1, {1'b1, 32'h0}, g);
    wait_rvalid(c);
    check("to_latency", 32'(c - g), 32'd10);
    check("to_psel_dropped", 32'(psel), 32'd0);
    check("to_penable_dropped", 32'(penable), 32'd0);
    #1 check("to_psel_cycles", 32'(psel_cycles), 32'd9);
    never_rdy[0] = 1'b0;

    // Back-to-back with req held: read c1, read c0, write c2
    b2b_addr[0] = 32'h0003_1000; b2b_we[0] = 1'b0; b2b_exp[0] = {1'b0, 32'hCAFE_0001};
    b2b_addr[1] = 32'h0003_0004; b2b_we[1] = 1'b0; b2b_exp[1] = {1'b0, 32'hD00D_0000};
    b2b_addr[2] = 32'h0003_2008; b2b_we[2] = 1'b1; b2b_exp[2] = {1'b0, 32'h0};
    @(posedge clk); #1;
    obi_req = 1'b1; obi_addr = b2b_addr[0]; obi_we = b2b_we[0]; obi_be = 4'hF; obi_wdata = 32'hA5A5_0000;
    begin
      int n;
      n = 0;
      for (int i = 0; i < 30 && n < 3; i++) begin
        @(negedge clk);
        if (obi_gnt === 1'b1) begin
          gcyc[n] = cyc;
          exp_q.push_back(b2b_exp[n]);
          n++;
        end
        @(posedge clk); #1;
        if (n == 3) obi_req = 1'b0;
        else begin
          obi_addr = b2b_addr[n]; obi_we = b2b_we[n];
        end
      end
      check("b2b_grants", 32'(n), 32'd3);
    end
    obi_req = 1'b0;
    wait_rvalid(c);
    check("b2b_gap01", 32'(gcyc[1] - gcyc[0]), 32'd3);
    check("b2b_gap12", 32'(gcyc[2] - gcyc[1]), 32'd3);
    check("b2b_last_latency", 32'(c - gcyc[2]), 32'd3);

    // Reset pulsed during ACCESS aborts without a response
    never_rdy[0] = 1'b1;
    grant_one(32'h0003_0020, 1'b0, 4'hF, 32'h0, 1'b0, 33'h0, g);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstacc_penable_before", 32'(penable), 32'd1);
    rv_before = rv_count;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstacc_psel", 32'(psel), 32'd0);
    check("rstacc_penable", 32'(penable), 32'd0);
    check("rstacc_state", 32'(state), 32'(ST_IDLE));
    repeat (6) @(negedge clk);
    #1 check("rstacc_no_rvalid", 32'(rv_count - rv_before), 32'd0);
    never_rdy[0] = 1'b0;
    grant_one(32'h0003_1004, 1'b0, 4'hF, 32'h0, 1'b1, {1'b0, 32'hCAFE_0001}, g);
    wait_rvalid(c);
    check("post_rst_latency", 32'(c - g), 32'd3);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed %0d checks", total);
    $fatal(1, "watchdog expired");
  end

endmodule
